// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter: CPU port 0 has priority, port 1 gets a starvation override.
// One access at a time is forwarded to sram_ctrl; completion is a registered one-cycle ack per port.
module sram_arbiter #(
  parameter int READ_CYCLES  = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [19:0] addr0_i,
  input  logic [19:0] addr1_i,
  input  logic [3:0]  be0_i,
  input  logic [3:0]  be1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        busy_o,
  output logic        owner_o,
  output logic        mem_enable_o,
  output logic        mem_read_o,
  output logic [19:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_busy_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] LP_RD_LAST = 4'(READ_CYCLES - 1);
  localparam logic [7:0] LP_STARVE  = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_wait1;

  logic        w_any;
  logic        w_pick1;
  logic        w_we;

  assign w_any   = req0_i | req1_i;
  assign w_pick1 = req1_i & ((r_wait1 >= LP_STARVE) | ~req0_i);
  assign w_we    = w_pick1 ? we1_i : we0_i;

  // Port 1 wait age; cleared while idle-requesting or on its own ack.
  always_ff @(posedge clk25) begin
    if (rst) begin
      r_wait1 <= 8'd0;
    end else if (!req1_i || ack1_o) begin
      r_wait1 <= 8'd0;
    end else if (r_wait1 != 8'hFF) begin
      r_wait1 <= r_wait1 + 8'd1;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      ack0_o       <= 1'b0;
      ack1_o       <= 1'b0;
      rdata0_o     <= 32'd0;
      rdata1_o     <= 32'd0;
      busy_o       <= 1'b0;
      owner_o      <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_addr_o   <= 20'd0;
      mem_be_o     <= 4'd0;
      mem_wdata_o  <= 32'd0;
    end else begin
      ack0_o <= 1'b0;
      ack1_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (w_any) begin
            owner_o      <= w_pick1;
            mem_addr_o   <= w_pick1 ? addr1_i : addr0_i;
            mem_be_o     <= w_pick1 ? be1_i : be0_i;
            mem_wdata_o  <= w_pick1 ? wdata1_i : wdata0_i;
            mem_enable_o <= 1'b1;
            mem_read_o   <= ~w_we;
            busy_o       <= 1'b1;
            r_state      <= w_we ? S_WRITE : S_READ;
          end
        end
        S_READ: begin
          if (r_cnt == LP_RD_LAST) begin
            if (owner_o) begin
              rdata1_o <= mem_rdata_i;
              ack1_o   <= 1'b1;
            end else begin
              rdata0_o <= mem_rdata_i;
              ack0_o   <= 1'b1;
            end
            mem_enable_o <= 1'b0;
            mem_read_o   <= 1'b0;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WRITE: begin
          // sram_ctrl raises busy a cycle late, so the first WRITE cycle ignores it.
          if (r_cnt == 4'd0) begin
            r_cnt <= 4'd1;
          end else if (!mem_busy_i) begin
            ack0_o       <= ~owner_o;
            ack1_o       <= owner_o;
            mem_enable_o <= 1'b0;
            mem_read_o   <= 1'b0;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a per-cycle vector table for the basic traces,
// then hand-written sequences for starvation override and reset mid-read.
module tb_sram_arbiter;

  localparam logic [31:0] D_RD   = 32'hDEADBEEF;
  localparam logic [31:0] D_BAD  = 32'h0BADF00D;
  localparam logic [31:0] D_R1   = 32'h11111111;
  localparam logic [31:0] D_R2   = 32'h22222222;
  localparam logic [19:0] A0     = 20'h00010;
  localparam logic [19:0] A1     = 20'h00020;
  localparam logic [3:0]  BE0    = 4'hF;
  localparam logic [3:0]  BE1    = 4'b0011;
  localparam logic [31:0] WD0    = 32'hAAAA5555;
  localparam logic [31:0] WD1    = 32'h12345678;

  logic        clk25 = 1'b0;
  logic        rst;
  logic        req0_i, req1_i, we0_i, we1_i;
  logic [19:0] addr0_i, addr1_i;
  logic [3:0]  be0_i, be1_i;
  logic [31:0] wdata0_i, wdata1_i;
  logic        ack0_o, ack1_o;
  logic [31:0] rdata0_o, rdata1_o;
  logic        busy_o, owner_o, mem_enable_o, mem_read_o;
  logic [19:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_busy_i;
  logic [31:0] mem_rdata_i;

  int checks   = 0;
  int failures = 0;

  always #20 clk25 = ~clk25;

  sram_arbiter #(.READ_CYCLES(2), .STARVE_LIMIT(8)) dut (
    .clk25(clk25), .rst(rst),
    .req0_i(req0_i), .req1_i(req1_i), .we0_i(we0_i), .we1_i(we1_i),
    .addr0_i(addr0_i), .addr1_i(addr1_i), .be0_i(be0_i), .be1_i(be1_i),
    .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
    .ack0_o(ack0_o), .ack1_o(ack1_o), .rdata0_o(rdata0_o), .rdata1_o(rdata1_o),
    .busy_o(busy_o), .owner_o(owner_o), .mem_enable_o(mem_enable_o), .mem_read_o(mem_read_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_busy_i(mem_busy_i), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {
    logic        r0, w0, r1, w1, mb;
    logic [31:0] mrd;
    logic        a0, a1, bz, own, en, rd;
    logic [1:0]  lat;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs[31];

  function automatic vec_t mk(input logic [4:0] in_b, input logic [31:0] mrd,
                              input logic [5:0] out_b, input logic [1:0] lat,
                              input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    {v.r0, v.w0, v.r1, v.w1, v.mb}       = in_b;
    v.mrd                                = mrd;
    {v.a0, v.a1, v.bz, v.own, v.en, v.rd} = out_b;
    v.lat                                = lat;
    v.rd0                                = rd0;
    v.rd1                                = rd1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk25);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [19:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;

    // port 0 read
    vecs[0]  = mk(5'b10000, D_RD,  6'b000000, 2'd0, 32'h0, 32'h0);
    vecs[1]  = mk(5'b10000, D_RD,  6'b001011, 2'd1, 32'h0, 32'h0);
    vecs[2]  = mk(5'b10000, D_RD,  6'b001011, 2'd1, 32'h0, 32'h0);
    vecs[3]  = mk(5'b10000, D_RD,  6'b101000, 2'd1, D_RD,  32'h0);
    vecs[4]  = mk(5'b00000, D_RD,  6'b000000, 2'd1, D_RD,  32'h0);
    // port 1 write, busy high for four cycles
    vecs[5]  = mk(5'b00110, D_BAD, 6'b000000, 2'd1, D_RD,  32'h0);
    vecs[6]  = mk(5'b00111, D_BAD, 6'b001110, 2'd2, D_RD,  32'h0);
    vecs[7]  = mk(5'b00111, D_BAD, 6'b001110, 2'd2, D_RD,  32'h0);
    vecs[8]  = mk(5'b00111, D_BAD, 6'b001110, 2'd2, D_RD,  32'h0);
    vecs[9]  = mk(5'b00111, D_BAD, 6'b001110, 2'd2, D_RD,  32'h0);
    vecs[10] = mk(5'b00110, D_BAD, 6'b001110, 2'd2, D_RD,  32'h0);
    vecs[11] = mk(5'b00110, D_BAD, 6'b011100, 2'd2, D_RD,  32'h0);
    vecs[12] = mk(5'b00000, D_BAD, 6'b000100, 2'd2, D_RD,  32'h0);
    // simultaneous reads, port 0 first
    vecs[13] = mk(5'b10100, D_R1,  6'b000100, 2'd2, D_RD,  32'h0);
    vecs[14] = mk(5'b10100, D_R1,  6'b001011, 2'd1, D_RD,  32'h0);
    vecs[15] = mk(5'b10100, D_R1,  6'b001011, 2'd1, D_RD,  32'h0);
    vecs[16] = mk(5'b10100, D_R1,  6'b101000, 2'd1, D_R1,  32'h0);
    vecs[17] = mk(5'b00100, D_R2,  6'b000000, 2'd1, D_R1,  32'h0);
    vecs[18] = mk(5'b00100, D_R2,  6'b001111, 2'd2, D_R1,  32'h0);
    vecs[19] = mk(5'b00100, D_R2,  6'b001111, 2'd2, D_R1,  32'h0);
    vecs[20] = mk(5'b00100, D_R2,  6'b011100, 2'd2, D_R1,  D_R2);
    vecs[21] = mk(5'b00000, D_R2,  6'b000100, 2'd2, D_R1,  D_R2);
    // port 0 write held past ack, then dropped mid-transaction
    vecs[22] = mk(5'b11000, D_BAD, 6'b000100, 2'd2, D_R1,  D_R2);
    vecs[23] = mk(5'b11001, D_BAD, 6'b001010, 2'd1, D_R1,  D_R2);
    vecs[24] = mk(5'b11000, D_BAD, 6'b001010, 2'd1, D_R1,  D_R2);
    vecs[25] = mk(5'b11000, D_BAD, 6'b101000, 2'd1, D_R1,  D_R2);
    vecs[26] = mk(5'b11000, D_BAD, 6'b000000, 2'd1, D_R1,  D_R2);
    vecs[27] = mk(5'b01000, D_BAD, 6'b001010, 2'd1, D_R1,  D_R2);
    vecs[28] = mk(5'b01000, D_BAD, 6'b001010, 2'd1, D_R1,  D_R2);
    vecs[29] = mk(5'b01000, D_BAD, 6'b101000, 2'd1, D_R1,  D_R2);
    vecs[30] = mk(5'b00000, D_BAD, 6'b000000, 2'd1, D_R1,  D_R2);

    rst = 1'b1;
    req0_i = 1'b0; req1_i = 1'b0; we0_i = 1'b0; we1_i = 1'b0;
    addr0_i = A0; addr1_i = A1; be0_i = BE0; be1_i = BE1;
    wdata0_i = WD0; wdata1_i = WD1;
    mem_busy_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) next_cycle();
    rst = 1'b0;

    for (int i = 0; i < 31; i++) begin
      req0_i = vecs[i].r0; we0_i = vecs[i].w0;
      req1_i = vecs[i].r1; we1_i = vecs[i].w1;
      mem_busy_i = vecs[i].mb; mem_rdata_i = vecs[i].mrd;
      @(negedge clk25);
      e_addr = (vecs[i].lat == 2'd1) ? A0  : (vecs[i].lat == 2'd2) ? A1  : 20'h0;
      e_be   = (vecs[i].lat == 2'd1) ? BE0 : (vecs[i].lat == 2'd2) ? BE1 : 4'h0;
      e_wd   = (vecs[i].lat == 2'd1) ? WD0 : (vecs[i].lat == 2'd2) ? WD1 : 32'h0;
      chk($sformatf("row%0d ack0", i),   32'(ack0_o),       32'(vecs[i].a0));
      chk($sformatf("row%0d ack1", i),   32'(ack1_o),       32'(vecs[i].a1));
      chk($sformatf("row%0d busy", i),   32'(busy_o),       32'(vecs[i].bz));
      chk($sformatf("row%0d owner", i),  32'(owner_o),      32'(vecs[i].own));
      chk($sformatf("row%0d en", i),     32'(mem_enable_o), 32'(vecs[i].en));
      chk($sformatf("row%0d rd", i),     32'(mem_read_o),   32'(vecs[i].rd));
      chk($sformatf("row%0d addr", i),   32'(mem_addr_o),   32'(e_addr));
      chk($sformatf("row%0d be", i),     32'(mem_be_o),     32'(e_be));
      chk($sformatf("row%0d wdata", i),  mem_wdata_o,       e_wd);
      chk($sformatf("row%0d rdata0", i), rdata0_o,          vecs[i].rd0);
      chk($sformatf("row%0d rdata1", i), rdata1_o,          vecs[i].rd1);
      next_cycle();
    end

    // Starvation: port 0 reads back-to-back while port 1 waits.
    we0_i = 1'b0; we1_i = 1'b0; mem_busy_i = 1'b0;
    for (int c = 0; c < 17; c++) begin
      req0_i = (c < 16);
      req1_i = (c < 12);
      mem_rdata_i = 32'hCAFE0000 | 32'(c);
      @(negedge clk25);
      chk($sformatf("starve c%0d ack0", c), 32'(ack0_o), 32'((c == 3) || (c == 7) || (c == 15)));
      chk($sformatf("starve c%0d ack1", c), 32'(ack1_o), 32'(c == 11));
      if (c == 8)  chk("starve wait1 at limit", 32'(dut.r_wait1), 32'd8);
      if (c == 9)  chk("starve port1 owner", 32'(owner_o), 32'd1);
      if (c == 11) chk("starve rdata1", rdata1_o, 32'hCAFE000A);
      if (c == 12) chk("starve wait1 cleared", 32'(dut.r_wait1), 32'd0);
      if (c == 13) chk("starve port0 resumes", 32'(owner_o), 32'd0);
      if (c == 16) chk("starve idle at end", 32'(busy_o), 32'd0);
      next_cycle();
    end

    // Reset during READ cycle 1 of a port 1 read.
    req1_i = 1'b1; we1_i = 1'b0; mem_rdata_i = 32'h33333333;
    next_cycle();
    rst = 1'b1;
    @(negedge clk25);
    chk("rstmid en before reset", 32'(mem_enable_o), 32'd1);
    next_cycle();
    rst = 1'b0; req1_i = 1'b0;
    @(negedge clk25);
    chk("rstmid busy",   32'(busy_o),       32'd0);
    chk("rstmid owner",  32'(owner_o),      32'd0);
    chk("rstmid en",     32'(mem_enable_o), 32'd0);
    chk("rstmid rd",     32'(mem_read_o),   32'd0);
    chk("rstmid addr",   32'(mem_addr_o),   32'd0);
    chk("rstmid be",     32'(mem_be_o),     32'd0);
    chk("rstmid wdata",  mem_wdata_o,       32'd0);
    chk("rstmid rdata0", rdata0_o,          32'd0);
    chk("rstmid rdata1", rdata1_o,          32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rstmid no ack1 c%0d", c), 32'(ack1_o), 32'd0);
      chk($sformatf("rstmid idle c%0d", c),    32'(busy_o), 32'd0);
      next_cycle();
      @(negedge clk25);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
